// File: rtl/command_uart_sender.sv
// command_uart_sender: queues toggle-marked command bytes, sends each as 8N1.
// Ports: clk; rst (async, active-high); data_in = {mark, byte};
//   tx serial line; busy, fifo_full status; overflow = one-cycle drop pulse.
module command_uart_sender #(
  parameter int BAUD_DIV   = 10417,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [AW:0] DEPTH_C =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic armed_q;
  logic mark_q;
  logic evt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;
  logic          drop;
  logic          not_empty;

  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic          baud_end;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          ovf_q;

  // armed_q stays low for the first clock after reset so a mark
  // level held through reset is absorbed rather than sent.
  assign evt = armed_q & (data_in[8] ^ mark_q);

  assign not_empty = (count != '0);
  assign fifo_full = (count == DEPTH_C);

  // The head is popped only from IDLE, so a full FIFO can still take
  // a new byte in that one cycle.
  assign pop  = (state_q == IDLE) & not_empty;
  assign push = evt & (~fifo_full | pop);
  assign drop = evt & fifo_full & ~pop;

  assign busy     = (state_q != IDLE) | not_empty;
  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_q  <= 1'b0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mark_q  <= data_in[8];
      armed_q <= 1'b1;
      ovf_q   <= drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d follows the current state; registering it delays the line
  // by one clock but keeps every bit exactly BAUD_DIV cycles long.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d   = 1'b0;
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d   = shift_q[0];
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/command_uart_sender.md
COMMAND_UART_SENDER -- requirements
Module: command_uart_sender

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 10417, giving clock cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of command bytes buffered; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  9  command word from the button-operation stage; [7:0] command byte, [8] toggle mark (each toggle = one new command).
REQ-006 tx  output  1  UART serial line, 8N1, idle high.
REQ-007 busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-008 fifo_full  output  1  high when FIFO holds FIFO_DEPTH entries.
REQ-009 overflow  output  1  one-cycle pulse when a command is dropped.

Function
REQ-010 The block SHALL register data_in[8] into mark_q every cycle; a command event SHALL be flagged in any cycle where data_in[8] != mark_q, except the first cycle after reset release.
REQ-011 On the first cycle after reset release, the block SHALL load mark_q from data_in[8] without flagging an event (no spurious send after reset).
REQ-012 On an event, data_in[7:0] sampled in that same cycle SHALL be pushed into the FIFO at that clock edge.
REQ-013 An event with FIFO full and no pop in the same cycle SHALL drop the byte, leave FIFO contents unchanged, and pulse overflow high for exactly one cycle.
REQ-014 An event with FIFO full and a pop in the same cycle SHALL be accepted (pop and push both performed, count unchanged).
REQ-015 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly first-in first-out.
REQ-016 The transmitter FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if FIFO non-empty, pop head into shift register, clear bit counter and baud counter, go to START.
REQ-018 START: tx=0 for exactly BAUD_DIV cycles, then go to DATA.
REQ-019 DATA: tx = shift register bit 0, each bit held BAUD_DIV cycles, LSB first; after 8 bits go to STOP.
REQ-020 STOP: tx=1 for exactly BAUD_DIV cycles, then go to IDLE.
REQ-021 tx SHALL be driven from a register (glitch-free); total frame = 10*BAUD_DIV cycles.
REQ-022 Latency: with FSM in IDLE and FIFO empty, an event at edge N SHALL push at N, pop at N+1, and tx SHALL go low after edge N+2.
REQ-023 Back-to-back frames: if FIFO non-empty at end of STOP, the next start bit SHALL begin after exactly one IDLE cycle.
REQ-024 Baud counter SHALL be ceil(log2(BAUD_DIV)) bits wide, counting 0..BAUD_DIV-1 and wrapping to 0.
REQ-025 busy SHALL be high whenever state != IDLE or FIFO count != 0; fifo_full SHALL equal (count == FIFO_DEPTH) combinationally from registered count.
REQ-026 Events arriving during a frame SHALL be buffered and never corrupt the frame in flight.

Reset
REQ-027 Asserting rst SHALL immediately, without a clock, set tx=1, busy=0, fifo_full=0, overflow=0, state=IDLE, FIFO pointers and count=0, mark_q=0, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame (tx high at once); buffered bytes SHALL be discarded.

Verification (BAUD_DIV=4, FIFO_DEPTH=4)
REQ-029 Single command: toggle data_in[8] 0->1 with [7:0]=0x06 -> tx low 2 cycles later, frame bits 0,0,1,1,0,0,0,0,0,1 each 4 cycles; busy falls after stop bit.
REQ-030 Burst: 5 toggles on consecutive cycles with bytes 0x06,0x0A,0x12,0x22,0x42 -> first pops immediately, remaining 4 fill FIFO, no overflow; 5 frames in order, one idle cycle between frames.
REQ-031 Overflow: 6 toggles on consecutive cycles -> 6th byte dropped, overflow high exactly one cycle, fifo_full high, only 5 frames sent.
REQ-032 Post-reset mark: hold data_in[8]=1 through reset release -> no frame, busy stays 0; subsequent 1->0 toggle sends one frame.
REQ-033 Mid-frame reset: assert rst during DATA bit 3 of frame 0x42 with 2 queued -> tx=1 same cycle, busy=0, no further frames after release.
REQ-034 Full-with-pop: FIFO full, toggle in the cycle IDLE pops -> byte accepted, overflow stays 0, count stays 4.
